// File: rtl/axi_depacketizer.sv
// axi_depacketizer: replays one scheduled packet as an AXI4 master burst.
// One transaction in flight; B/R responses are forwarded to the slave side.
module axi_depacketizer #(
  parameter int C_M_AXI_ID_WIDTH   = 16,
  parameter int C_M_AXI_ADDR_WIDTH = 40,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_M_AXI_USER_WIDTH = 16,
  parameter int MAX_BURST_LEN      = 4,
  parameter int PKT_WIDTH          = 30 + C_M_AXI_ADDR_WIDTH
                                   + C_M_AXI_ID_WIDTH + C_M_AXI_USER_WIDTH
                                   + MAX_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8)
                                   + MAX_BURST_LEN * C_M_AXI_DATA_WIDTH
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [PKT_WIDTH-1:0]          packetIn,
  input  logic                          packetValid,
  output logic                          packetReady,
  output logic                          protocolError,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWLOCK,
  output logic [3:0]                    M_AXI_AWCACHE,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic [3:0]                    M_AXI_AWQOS,
  output logic [3:0]                    M_AXI_AWREGION,
  output logic [C_M_AXI_USER_WIDTH-1:0] M_AXI_AWUSER,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_BID,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic [3:0]                    M_AXI_ARREGION,
  output logic [C_M_AXI_USER_WIDTH-1:0] M_AXI_ARUSER,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_M_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int UW = C_M_AXI_USER_WIDTH;
  localparam int MW = 30 + C_M_AXI_ADDR_WIDTH
                    + C_M_AXI_ID_WIDTH + UW;
  localparam int CW = (MAX_BURST_LEN > 1) ?
                      $clog2(MAX_BURST_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R
  } state_t;

  state_t                    state;
  logic [MW-2:0]             meta_q;
  logic [MAX_BURST_LEN*SW-1:0] strb_q;
  logic [MAX_BURST_LEN*DW-1:0] data_q;
  logic [CW-1:0]             cnt;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      arvalid_q;
  logic                      perr_q;

  logic [MW-1:0]             pkt_meta;
  logic                      in_wr;
  logic [7:0]                in_len;

  logic [C_M_AXI_ADDR_WIDTH-1:0] q_addr;
  logic [C_M_AXI_ID_WIDTH-1:0]   q_id;
  logic [7:0]                q_len;
  logic [2:0]                q_size;
  logic [1:0]                q_burst;
  logic                      q_lock;
  logic [3:0]                q_cache;
  logic [2:0]                q_prot;
  logic [3:0]                q_qos;
  logic [3:0]                q_region;
  logic [UW-1:0]             q_user;

  logic [DW-1:0]             data_slot [MAX_BURST_LEN];
  logic [SW-1:0]             strb_slot [MAX_BURST_LEN];
  logic                      w_last;
  logic                      in_b;
  logic                      in_r;

  assign pkt_meta = packetIn[PKT_WIDTH-1 -: MW];
  assign in_wr    = pkt_meta[MW-1];
  assign in_len   = pkt_meta[UW+21 +: 8];

  assign {q_addr, q_id, q_len, q_size, q_burst, q_lock,
          q_cache, q_prot, q_qos, q_region, q_user} = meta_q;

  for (genvar i = 0; i < MAX_BURST_LEN; i++) begin : g_slot
    assign data_slot[i] = data_q[(MAX_BURST_LEN-1-i)*DW +: DW];
    assign strb_slot[i] = strb_q[(MAX_BURST_LEN-1-i)*SW +: SW];
  end

  assign w_last = (8'(cnt) == q_len);
  assign in_b   = (state == S_B);
  assign in_r   = (state == S_R);

  assign packetReady   = (state == S_IDLE);
  assign protocolError = perr_q;

  assign M_AXI_AWID     = q_id;
  assign M_AXI_AWADDR   = q_addr;
  assign M_AXI_AWLEN    = q_len;
  assign M_AXI_AWSIZE   = q_size;
  assign M_AXI_AWBURST  = q_burst;
  assign M_AXI_AWLOCK   = q_lock;
  assign M_AXI_AWCACHE  = q_cache;
  assign M_AXI_AWPROT   = q_prot;
  assign M_AXI_AWQOS    = q_qos;
  assign M_AXI_AWREGION = q_region;
  assign M_AXI_AWUSER   = q_user;
  assign M_AXI_AWVALID  = awvalid_q;

  assign M_AXI_WDATA  = data_slot[cnt];
  assign M_AXI_WSTRB  = strb_slot[cnt];
  assign M_AXI_WLAST  = w_last;
  assign M_AXI_WVALID = wvalid_q;

  assign M_AXI_ARID     = q_id;
  assign M_AXI_ARADDR   = q_addr;
  assign M_AXI_ARLEN    = q_len;
  assign M_AXI_ARSIZE   = q_size;
  assign M_AXI_ARBURST  = q_burst;
  assign M_AXI_ARLOCK   = q_lock;
  assign M_AXI_ARCACHE  = q_cache;
  assign M_AXI_ARPROT   = q_prot;
  assign M_AXI_ARQOS    = q_qos;
  assign M_AXI_ARREGION = q_region;
  assign M_AXI_ARUSER   = q_user;
  assign M_AXI_ARVALID  = arvalid_q;

  assign S_AXI_BID    = in_b ? M_AXI_BID : '0;
  assign S_AXI_BRESP  = in_b ? M_AXI_BRESP : '0;
  assign S_AXI_BVALID = in_b & M_AXI_BVALID;
  assign M_AXI_BREADY = in_b & S_AXI_BREADY;

  assign S_AXI_RID    = in_r ? M_AXI_RID : '0;
  assign S_AXI_RDATA  = in_r ? M_AXI_RDATA : '0;
  assign S_AXI_RRESP  = in_r ? M_AXI_RRESP : '0;
  assign S_AXI_RLAST  = in_r & M_AXI_RLAST;
  assign S_AXI_RVALID = in_r & M_AXI_RVALID;
  assign M_AXI_RREADY = in_r & S_AXI_RREADY;

  // Packet capture and AW/W/B or AR/R sequencing with registered valids.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state     <= S_IDLE;
      meta_q    <= '0;
      strb_q    <= '0;
      data_q    <= '0;
      cnt       <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (packetValid) begin
            meta_q <= pkt_meta[MW-2:0];
            strb_q <= packetIn[MAX_BURST_LEN*DW +: MAX_BURST_LEN*SW];
            data_q <= packetIn[0 +: MAX_BURST_LEN*DW];
            cnt    <= '0;
            if (32'(in_len) >= MAX_BURST_LEN) begin
              perr_q <= 1'b1;
            end else if (in_wr) begin
              awvalid_q <= 1'b1;
              state     <= S_AW;
            end else begin
              arvalid_q <= 1'b1;
              state     <= S_AR;
            end
          end
        end
        S_AW: begin
          if (M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            cnt       <= '0;
            state     <= S_W;
          end
        end
        S_W: begin
          if (M_AXI_WREADY) begin
            if (w_last) begin
              wvalid_q <= 1'b0;
              state    <= S_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_B: begin
          if (M_AXI_BVALID && S_AXI_BREADY) state <= S_IDLE;
        end
        S_AR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            state     <= S_R;
          end
        end
        S_R: begin
          if (M_AXI_RVALID && S_AXI_RREADY && M_AXI_RLAST)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_depacketizer.sv
// tb_axi_depacketizer: directed packets, queued expectations,
// negedge monitor compares every AXI beat the DUT presents.
module tb_axi_depacketizer;

  localparam int PW = 678;
  localparam logic [36:0] FIX =
    {3'd4, 2'b01, 1'b1, 4'h3, 3'd2, 4'h5, 4'h9, 16'h00AB};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [PW-1:0] packetIn;
  logic          packetValid, packetReady, protocolError;
  logic [15:0]  awid;  logic [39:0] awaddr; logic [7:0] awlen;
  logic [2:0]   awsize; logic [1:0] awburst; logic awlock;
  logic [3:0]   awcache; logic [2:0] awprot; logic [3:0] awqos;
  logic [3:0]   awregion; logic [15:0] awuser;
  logic         awvalid, awready;
  logic [127:0] wdata; logic [15:0] wstrb;
  logic         wlast, wvalid, wready;
  logic [15:0]  bid; logic [1:0] bresp; logic bvalid, bready;
  logic [15:0]  arid;  logic [39:0] araddr; logic [7:0] arlen;
  logic [2:0]   arsize; logic [1:0] arburst; logic arlock;
  logic [3:0]   arcache; logic [2:0] arprot; logic [3:0] arqos;
  logic [3:0]   arregion; logic [15:0] aruser;
  logic         arvalid, arready;
  logic [15:0]  rid; logic [127:0] rdata; logic [1:0] rresp;
  logic         rlast, rvalid, rready;
  logic [15:0]  sbid; logic [1:0] sbresp; logic sbvalid, sbready;
  logic [15:0]  srid; logic [127:0] srdata; logic [1:0] srresp;
  logic         srlast, srvalid, srready;

  axi_depacketizer dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .packetIn(packetIn), .packetValid(packetValid),
    .packetReady(packetReady), .protocolError(protocolError),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
    .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
    .M_AXI_AWREGION(awregion), .M_AXI_AWUSER(awuser),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARREGION(arregion), .M_AXI_ARUSER(aruser),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .S_AXI_BID(sbid), .S_AXI_BRESP(sbresp), .S_AXI_BVALID(sbvalid),
    .S_AXI_BREADY(sbready),
    .S_AXI_RID(srid), .S_AXI_RDATA(srdata), .S_AXI_RRESP(srresp),
    .S_AXI_RLAST(srlast), .S_AXI_RVALID(srvalid),
    .S_AXI_RREADY(srready)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [159:0] exp_aw[$], exp_w[$], exp_ar[$], exp_b[$], exp_r[$];
  int exp_perr[$];

  logic [3:0][127:0] wd, rd, zd;
  logic [3:0][15:0]  ws, zs;
  logic [PW-1:0]     rpkt;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got valid=1 expected valid=0", nm);
  endtask

  function automatic logic [159:0] axf(input logic [39:0] a,
                                       input logic [15:0] id,
                                       input logic [7:0] len);
    return 160'({a, id, len, FIX});
  endfunction

  function automatic logic [PW-1:0] mk_pkt(
      input logic isw, input logic [39:0] a, input logic [15:0] id,
      input logic [7:0] len, input logic [3:0][127:0] d,
      input logic [3:0][15:0] s);
    return {isw, a, id, len, FIX, s[0], s[1], s[2], s[3],
            d[0], d[1], d[2], d[3]};
  endfunction

  // monitor: every presented beat is compared with the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (awvalid) begin
        if (exp_aw.size() == 0) unexp("aw");
        else begin
          chk("aw", 160'({awaddr, awid, awlen, awsize, awburst, awlock,
                          awcache, awprot, awqos, awregion, awuser}),
              exp_aw[0]);
          if (awready) void'(exp_aw.pop_front());
        end
      end
      if (wvalid) begin
        if (exp_w.size() == 0) unexp("w");
        else begin
          chk("w", 160'({wstrb, wdata, wlast}), exp_w[0]);
          if (wready) void'(exp_w.pop_front());
        end
      end
      if (arvalid) begin
        if (exp_ar.size() == 0) unexp("ar");
        else begin
          chk("ar", 160'({araddr, arid, arlen, arsize, arburst, arlock,
                          arcache, arprot, arqos, arregion, aruser}),
              exp_ar[0]);
          if (arready) void'(exp_ar.pop_front());
        end
      end
      if (sbvalid) begin
        if (exp_b.size() == 0) unexp("s_b");
        else if (sbready)
          chk("s_b", 160'({sbid, sbresp}), exp_b.pop_front());
      end
      if (srvalid) begin
        if (exp_r.size() == 0) unexp("s_r");
        else if (srready)
          chk("s_r", 160'({srid, srdata, srresp, srlast}),
              exp_r.pop_front());
      end
      if (protocolError) begin
        if (exp_perr.size() == 0) unexp("perr");
        else chk_i("perr", int'(protocolError), exp_perr.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present a packet until accepted; returns at T+1
  task automatic send(input logic [PW-1:0] p);
    int k;
    packetIn = p;
    packetValid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (packetReady) break;
      step();
      k++;
      if (k > 50) begin
        chk_i("accept_timeout", 0, 1);
        break;
      end
    end
    step();
    packetValid = 1'b0;
  endtask

  task automatic do_write(input logic [39:0] a, input logic [15:0] id,
                          input logic [7:0] len,
                          input logic [3:0][127:0] d,
                          input logic [3:0][15:0] s,
                          input int stall, input bit tog,
                          input bit hold, input logic [PW-1:0] nxt);
    int cyc, nw, prb;
    bit bp, done;
    exp_aw.push_back(axf(a, id, len));
    for (int i = 0; i <= int'(len); i++)
      exp_w.push_back(160'({s[i], d[i], (i == int'(len))}));
    exp_b.push_back(160'({id, 2'b01}));
    awready = (stall == 0);
    send(mk_pkt(1'b1, a, id, len, d, s));
    chk_i("aw_t1", int'(awvalid), 1);
    if (hold) begin
      packetIn = nxt;
      packetValid = 1'b1;
    end
    rvalid = 1'b1;
    rlast = 1'b1;
    rdata = {4{32'hDEAD_BEEF}};
    cyc = 0; nw = 0; prb = 0; bp = 0; done = 0;
    while (!done && cyc < 200) begin
      awready = (cyc >= stall);
      wready = tog ? ((cyc % 2) == 0) : 1'b1;
      bvalid = bp;
      bid = id;
      bresp = 2'b01;
      @(negedge clk);
      if (packetReady) prb++;
      if (wvalid && wready) begin
        nw++;
        if (wlast) bp = 1;
      end
      if (bvalid && bready) done = 1;
      step();
      cyc++;
    end
    bvalid = 1'b0;
    rvalid = 1'b0;
    rlast = 1'b0;
    chk_i("write_done", int'(done), 1);
    chk_i("w_count", nw, int'(len) + 1);
    chk_i("pr_busy", prb, 0);
    chk_i("pr_after_b", int'(packetReady), 1);
  endtask

  task automatic do_read(input logic [39:0] a, input logic [15:0] id,
                         input logic [7:0] len,
                         input logic [3:0][127:0] d);
    int cyc, bi;
    bit ra, done;
    exp_ar.push_back(axf(a, id, len));
    for (int i = 0; i <= int'(len); i++)
      exp_r.push_back(160'({id, d[i], 2'b00, (i == int'(len))}));
    arready = 1'b1;
    send(mk_pkt(1'b0, a, id, len, zd, zs));
    chk_i("ar_t1", int'(arvalid), 1);
    bvalid = 1'b1;
    bid = 16'hFFFF;
    bresp = 2'b11;
    cyc = 0; bi = 0; ra = 0; done = 0;
    while (!done && cyc < 200) begin
      rvalid = ra;
      rid = id;
      rdata = d[bi];
      rresp = 2'b00;
      rlast = (bi == int'(len));
      @(negedge clk);
      if (arvalid && arready) ra = 1;
      if (rvalid && rready) begin
        if (rlast) done = 1;
        else bi++;
      end
      step();
      cyc++;
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    bvalid = 1'b0;
    chk_i("read_done", int'(done), 1);
    chk_i("pr_after_r", int'(packetReady), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nw;
    zd = '0; zs = '0;
    rst = 1'b1;
    packetIn = '0; packetValid = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    sbready = 1'b1; srready = 1'b1;
    step();
    chk_i("rst_pready", int'(packetReady), 1);
    chk_i("rst_awvalid", int'(awvalid), 0);
    chk_i("rst_wvalid", int'(wvalid), 0);
    chk_i("rst_arvalid", int'(arvalid), 0);
    chk_i("rst_perr", int'(protocolError), 0);
    chk_i("rst_bready", int'(bready), 0);
    step();
    step();
    rst = 1'b0;
    step();

    // basic write LEN=3
    wd[0] = {32{4'hA}}; wd[1] = {32{4'hB}};
    wd[2] = {32{4'hC}}; wd[3] = {32{4'hD}};
    ws = {4{16'hFFFF}};
    do_write(40'h1000, 16'h0001, 8'd3, wd, ws, 0, 1'b0, 1'b0, '0);

    // read LEN=1
    rd[0] = {4{32'h1111_2222}}; rd[1] = {4{32'h3333_4444}};
    rd[2] = '0; rd[3] = '0;
    do_read(40'h2000, 16'h0001, 8'd1, rd);

    // backpressure: AW stall 5, WREADY toggling
    wd[0] = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    wd[1] = 128'h8899_AABB_CCDD_EEFF_FEDC_BA98_7654_3210;
    wd[2] = 128'h5555_0000_5555_0000_5555_0000_5555_0000;
    wd[3] = 128'h0000_AAAA_0000_AAAA_0000_AAAA_0000_AAAA;
    ws[0] = 16'h000F; ws[1] = 16'h00F0;
    ws[2] = 16'h0F00; ws[3] = 16'hF000;
    do_write(40'hAB_0000_3000, 16'h0042, 8'd3, wd, ws, 5, 1'b1, 1'b0, '0);

    // malformed LEN=7 and LEN=4 are dropped
    for (int m = 0; m < 2; m++) begin
      exp_perr.push_back(1);
      awready = 1'b1;
      send(mk_pkt(1'b1, 40'h4000, 16'h0007,
                  (m == 0) ? 8'd7 : 8'd4, wd, ws));
      chk_i("bad_perr_t1", int'(protocolError), 1);
      chk_i("bad_no_aw", int'(awvalid), 0);
      step();
      chk_i("bad_perr_t2", int'(protocolError), 0);
      chk_i("bad_pready", int'(packetReady), 1);
    end

    // next valid packet after drop, LEN=0 boundary
    do_write(40'h5000, 16'h0005, 8'd0, wd, ws, 0, 1'b0, 1'b0, '0);

    // reset after the 2nd W beat of a LEN=3 write
    exp_aw.push_back(axf(40'h6000, 16'h0006, 8'd3));
    for (int i = 0; i < 2; i++)
      exp_w.push_back(160'({ws[i], wd[i], 1'b0}));
    awready = 1'b1;
    wready = 1'b1;
    send(mk_pkt(1'b1, 40'h6000, 16'h0006, 8'd3, wd, ws));
    k = 0; nw = 0;
    while (nw < 2 && k < 50) begin
      @(negedge clk);
      if (wvalid && wready) nw++;
      step();
      k++;
    end
    chk_i("rst_mid_beats", nw, 2);
    rst = 1'b1;
    wready = 1'b0;
    step();
    chk_i("rst_mid_wvalid", int'(wvalid), 0);
    chk_i("rst_mid_pready", int'(packetReady), 1);
    chk_i("rst_mid_awvalid", int'(awvalid), 0);
    rst = 1'b0;
    rd[2] = {4{32'h5A5A_A5A5}}; rd[3] = {4{32'hC3C3_3C3C}};
    do_read(40'h7000, 16'h0009, 8'd3, rd);

    // back-to-back: read held valid during a write
    rd[0] = {4{32'h0BAD_F00D}};
    rpkt = mk_pkt(1'b0, 40'h8000, 16'h000B, 8'd0, zd, zs);
    do_write(40'h9000, 16'h000A, 8'd2, wd, ws, 0, 1'b0, 1'b1, rpkt);
    do_read(40'h8000, 16'h000B, 8'd0, rd);

    step();
    chk_i("queues_empty", exp_aw.size() + exp_w.size() + exp_ar.size()
          + exp_b.size() + exp_r.size() + exp_perr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
